// File: rtl/pipe_stage_reg.sv
// Elastic pipeline register: 2-entry skid buffer, flush-to-bubble, pc+8.
// Optional downstream-stall counter under `PIPE_STAGE_REG_STATS_EN.
module pipe_stage_reg #(
   parameter int                 INSTR_W   = 32,
   parameter int                 PC_W      = 32,
   parameter logic [PC_W-1:0]    RESET_PC  = 32'h0000_3000,
   parameter logic [INSTR_W-1:0] NOP_INSTR = '0
) (
   input  logic               clk,
   input  logic               reset,
   input  logic               in_valid,
   output logic               in_ready,
   input  logic [INSTR_W-1:0] in_instr,
   input  logic [PC_W-1:0]    in_pc,
   input  logic               flush,
   output logic               out_valid,
   input  logic               out_ready,
   output logic [INSTR_W-1:0] out_instr,
   output logic [PC_W-1:0]    out_pc,
   output logic [PC_W-1:0]    out_pc8,
   output logic [15:0]        stall_cnt
);

   logic               r_main_v;
   logic [INSTR_W-1:0] r_main_instr;
   logic [PC_W-1:0]    r_main_pc;
   logic               r_skid_v;
   logic [INSTR_W-1:0] r_skid_instr;
   logic [PC_W-1:0]    r_skid_pc;
   logic               r_in_rdy;

   logic w_acc;
   logic w_take;

   assign w_acc  = in_valid & r_in_rdy;
   assign w_take = r_main_v & out_ready;

   // r_in_rdy mirrors !r_skid_v so in_ready comes straight off a flop
   always_ff @(posedge clk) begin
      if (!reset) begin
         r_main_v     <= 1'b0;
         r_skid_v     <= 1'b0;
         r_in_rdy     <= 1'b1;
         r_main_instr <= NOP_INSTR;
         r_main_pc    <= RESET_PC;
      end else if (flush) begin
         r_main_v <= 1'b0;
         r_skid_v <= 1'b0;
         r_in_rdy <= 1'b1;
      end else if (r_skid_v) begin
         if (w_take) begin
            r_main_instr <= r_skid_instr;
            r_main_pc    <= r_skid_pc;
            r_skid_v     <= 1'b0;
            r_in_rdy     <= 1'b1;
         end
      end else if (r_main_v) begin
         if (w_acc && w_take) begin
            r_main_instr <= in_instr;
            r_main_pc    <= in_pc;
         end else if (w_take) begin
            r_main_v <= 1'b0;
         end else if (w_acc) begin
            r_skid_instr <= in_instr;
            r_skid_pc    <= in_pc;
            r_skid_v     <= 1'b1;
            r_in_rdy     <= 1'b0;
         end
      end else if (w_acc) begin
         r_main_instr <= in_instr;
         r_main_pc    <= in_pc;
         r_main_v     <= 1'b1;
      end
   end

   assign in_ready  = r_in_rdy;
   assign out_valid = r_main_v;
   assign out_instr = r_main_v ? r_main_instr : NOP_INSTR;
   assign out_pc    = r_main_pc;
   assign out_pc8   = r_main_pc + PC_W'(8);

`ifdef PIPE_STAGE_REG_STATS_EN
   logic [15:0] r_stall_cnt;

   always_ff @(posedge clk) begin
      if (!reset) begin
         r_stall_cnt <= 16'h0;
      end else if (r_main_v && !out_ready &&
                   r_stall_cnt != 16'hFFFF) begin
         r_stall_cnt <= r_stall_cnt + 16'd1;
      end
   end

   assign stall_cnt = r_stall_cnt;
`else
   assign stall_cnt = 16'h0;
`endif

endmodule

// File: tb/tb_pipe_stage_reg.sv
// Self-checking bench for pipe_stage_reg against a queue-based model.
// Stall-count expectations follow `PIPE_STAGE_REG_STATS_EN.
module tb_pipe_stage_reg;

   typedef struct {
      logic [31:0] i;
      logic [31:0] p;
   } beat_t;

   logic        clk;
   logic        reset;
   logic        in_valid;
   logic        in_ready;
   logic [31:0] in_instr;
   logic [31:0] in_pc;
   logic        flush;
   logic        out_valid;
   logic        out_ready;
   logic [31:0] out_instr;
   logic [31:0] out_pc;
   logic [31:0] out_pc8;
   logic [15:0] stall_cnt;

   int checks;
   int failures;

   beat_t       q[$];
   logic [31:0] m_pc;
   int          m_cnt;

   logic        last_acc;
   logic        last_tk;
   logic [31:0] last_tk_instr;

   pipe_stage_reg dut (
      .clk       (clk),
      .reset     (reset),
      .in_valid  (in_valid),
      .in_ready  (in_ready),
      .in_instr  (in_instr),
      .in_pc     (in_pc),
      .flush     (flush),
      .out_valid (out_valid),
      .out_ready (out_ready),
      .out_instr (out_instr),
      .out_pc    (out_pc),
      .out_pc8   (out_pc8),
      .stall_cnt (stall_cnt)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   // Reference: a FIFO of at most two beats plus last-head PC
   function automatic void model_step(
      input logic rst, input logic fl, input logic iv,
      input logic [31:0] ins, input logic [31:0] pcv,
      input logic ordy);
      beat_t b;
      logic  acc, tk;
      if (!rst) begin
         q.delete();
         m_pc  = 32'h3000;
         m_cnt = 0;
         return;
      end
      if (q.size() > 0 && !ordy && m_cnt < 65535) m_cnt++;
      if (fl) begin
         q.delete();
         return;
      end
      acc = iv && (q.size() < 2);
      tk  = (q.size() > 0) && ordy;
      if (tk) void'(q.pop_front());
      if (acc) begin
         b.i = ins;
         b.p = pcv;
         q.push_back(b);
      end
      if (q.size() > 0) m_pc = q[0].p;
   endfunction

   function automatic logic [113:0] exp_vec();
      logic        v;
      logic [15:0] c;
      v = q.size() > 0;
`ifdef PIPE_STAGE_REG_STATS_EN
      c = 16'(m_cnt);
`else
      c = 16'h0;
`endif
      return {v, q.size() < 2, v ? q[0].i : 32'h0,
              m_pc, m_pc + 32'd8, c};
   endfunction

   function automatic logic [113:0] got_vec();
      return {out_valid, in_ready, out_instr,
              out_pc, out_pc8, stall_cnt};
   endfunction

   task automatic cyc(
      input logic rst, input logic fl, input logic iv,
      input logic [31:0] ins, input logic [31:0] pcv,
      input logic ordy);
      reset     = rst;
      flush     = fl;
      in_valid  = iv;
      in_instr  = ins;
      in_pc     = pcv;
      out_ready = ordy;
      #1;
      last_acc      = iv & in_ready;
      last_tk       = out_valid & ordy;
      last_tk_instr = out_instr;
      @(posedge clk);
      model_step(rst, fl, iv, ins, pcv, ordy);
      #1;
   endtask

   task automatic test_reset();
      cyc(0, 0, 0, 0, 0, 0);
      cyc(0, 0, 1, 32'hABCD, 32'h10, 1);
      checks++;
      if (got_vec() !== exp_vec()) begin
         failures++;
         $display("FAIL reset_vec got=%h exp=%h",
                  got_vec(), exp_vec());
      end
      checks++;
      if ({out_valid, in_ready, out_instr} !== {1'b0, 1'b1, 32'h0}) begin
         failures++;
         $display("FAIL reset_flags got v=%b r=%b i=%h exp 0 1 0",
                  out_valid, in_ready, out_instr);
      end
      checks++;
      if ({out_pc, out_pc8, stall_cnt} !==
          {32'h3000, 32'h3008, 16'h0}) begin
         failures++;
         $display("FAIL reset_pc got pc=%h pc8=%h cnt=%h exp 3000 3008 0",
                  out_pc, out_pc8, stall_cnt);
      end
   endtask

   task automatic test_stream();
      logic [31:0] ins [3];
      logic [31:0] pcs [3];
      ins = '{32'h1111, 32'h2222, 32'h3333};
      pcs = '{32'h3000, 32'h3004, 32'h3008};
      for (int k = 0; k < 3; k++) begin
         cyc(1, 0, 1, ins[k], pcs[k], 1);
         checks++;
         if ({out_valid, out_instr, out_pc8} !==
             {1'b1, ins[k], pcs[k] + 32'd8}) begin
            failures++;
            $display("FAIL stream_beat%0d got v=%b i=%h pc8=%h exp i=%h pc8=%h",
                     k, out_valid, out_instr, out_pc8,
                     ins[k], pcs[k] + 32'd8);
         end
         checks++;
         if (got_vec() !== exp_vec()) begin
            failures++;
            $display("FAIL stream_vec%0d got=%h exp=%h",
                     k, got_vec(), exp_vec());
         end
      end
      cyc(1, 0, 0, 0, 0, 1);
      checks++;
      if (out_valid !== 1'b0) begin
         failures++;
         $display("FAIL stream_drain got v=%b exp 0", out_valid);
      end
   endtask

   task automatic test_backpressure();
      beat_t       src[$];
      logic [31:0] sent[$];
      logic [31:0] rcv[$];
      beat_t       b;
      int          n;
      for (int k = 0; k < 3; k++) begin
         b.i = 32'hAA00 + 32'(k);
         b.p = 32'h4000 + 32'(4 * k);
         src.push_back(b);
         sent.push_back(b.i);
      end
      for (int c = 0; c < 4; c++) begin
         cyc(1, 0, 1, src[0].i, src[0].p, 0);
         if (last_acc) void'(src.pop_front());
         checks++;
         if (in_ready !== (c == 0)) begin
            failures++;
            $display("FAIL bp_ready c%0d got=%b exp=%b",
                     c, in_ready, c == 0);
         end
         checks++;
         if (got_vec() !== exp_vec()) begin
            failures++;
            $display("FAIL bp_vec c%0d got=%h exp=%h",
                     c, got_vec(), exp_vec());
         end
      end
      checks++;
      if (src.size() !== 1) begin
         failures++;
         $display("FAIL bp_held got=%0d exp=1", src.size());
      end
      n = 0;
      while (rcv.size() < 3 && n < 12) begin
         if (src.size() > 0)
            cyc(1, 0, 1, src[0].i, src[0].p, 1);
         else
            cyc(1, 0, 0, 0, 0, 1);
         if (last_acc) void'(src.pop_front());
         if (last_tk) rcv.push_back(last_tk_instr);
         checks++;
         if (got_vec() !== exp_vec()) begin
            failures++;
            $display("FAIL bp_drain_vec n%0d got=%h exp=%h",
                     n, got_vec(), exp_vec());
         end
         n++;
      end
      checks++;
      if (rcv !== sent) begin
         failures++;
         $display("FAIL bp_order got n=%0d exp n=3 (%h %h %h)",
                  rcv.size(), sent[0], sent[1], sent[2]);
      end
   endtask

   task automatic test_flush();
      logic [31:0] prior;
      cyc(1, 0, 1, 32'h5555, 32'h5000, 0);
      cyc(1, 0, 1, 32'h6666, 32'h5004, 0);
      prior = 32'h5000;
      cyc(1, 1, 1, 32'hDEAD, 32'h6000, 0);
      checks++;
      if ({out_valid, out_instr, in_ready, out_pc} !==
          {1'b0, 32'h0, 1'b1, prior}) begin
         failures++;
         $display("FAIL flush_state got v=%b i=%h r=%b pc=%h exp 0 0 1 %h",
                  out_valid, out_instr, in_ready, out_pc, prior);
      end
      for (int c = 0; c < 3; c++) begin
         cyc(1, 0, 0, 0, 0, 1);
         checks++;
         if (out_valid !== 1'b0 || last_tk !== 1'b0) begin
            failures++;
            $display("FAIL flush_leak c%0d got v=%b tk=%b exp 0 0",
                     c, out_valid, last_tk);
         end
      end
      checks++;
      if (got_vec() !== exp_vec()) begin
         failures++;
         $display("FAIL flush_vec got=%h exp=%h",
                  got_vec(), exp_vec());
      end
   endtask

   task automatic test_reset_mid();
      cyc(1, 0, 1, 32'h7777, 32'h7000, 0);
      cyc(1, 0, 1, 32'h8888, 32'h7004, 0);
      cyc(0, 0, 1, 32'h9999, 32'h7008, 1);
      checks++;
      if ({out_pc, out_pc8, out_valid, in_ready} !==
          {32'h3000, 32'h3008, 1'b0, 1'b1}) begin
         failures++;
         $display("FAIL rst_mid got pc=%h pc8=%h v=%b r=%b exp 3000 3008 0 1",
                  out_pc, out_pc8, out_valid, in_ready);
      end
      cyc(1, 0, 0, 0, 0, 1);
      checks++;
      if (out_valid !== 1'b0) begin
         failures++;
         $display("FAIL rst_mid_leak got v=%b exp 0", out_valid);
      end
   endtask

   task automatic test_wrap();
      cyc(1, 0, 1, 32'hCAFE, 32'hFFFF_FFFC, 0);
      checks++;
      if (out_pc8 !== 32'h0000_0004) begin
         failures++;
         $display("FAIL wrap got=%h exp=00000004", out_pc8);
      end
      cyc(1, 0, 0, 0, 0, 1);
   endtask

   task automatic test_stats();
      logic [15:0] want;
      cyc(0, 0, 0, 0, 0, 1);
      cyc(1, 0, 1, 32'h1234, 32'h3000, 0);
      for (int c = 0; c < 5; c++) cyc(1, 0, 0, 0, 0, 0);
`ifdef PIPE_STAGE_REG_STATS_EN
      want = 16'd5;
`else
      want = 16'd0;
`endif
      checks++;
      if (stall_cnt !== want) begin
         failures++;
         $display("FAIL stats got=%0d exp=%0d", stall_cnt, want);
      end
      cyc(1, 1, 0, 0, 0, 0);
      cyc(1, 0, 0, 0, 0, 0);
      checks++;
      if (stall_cnt !== want) begin
         failures++;
         $display("FAIL stats_flush got=%0d exp=%0d", stall_cnt, want);
      end
   endtask

   task automatic test_random();
      logic rst, fl, iv, ordy;
      for (int c = 0; c < 400; c++) begin
         rst  = ($urandom % 60) != 0;
         fl   = ($urandom % 20) == 0;
         iv   = ($urandom % 4) != 0;
         ordy = ($urandom % 3) != 0;
         cyc(rst, fl, iv, $urandom, $urandom, ordy);
         checks++;
         if (got_vec() !== exp_vec()) begin
            failures++;
            $display("FAIL rand_vec c%0d got=%h exp=%h",
                     c, got_vec(), exp_vec());
         end
      end
   endtask

   initial begin
      checks    = 0;
      failures  = 0;
      reset     = 1'b0;
      flush     = 1'b0;
      in_valid  = 1'b0;
      in_instr  = '0;
      in_pc     = '0;
      out_ready = 1'b0;
      m_pc      = 32'h3000;
      m_cnt     = 0;
      test_reset();
      test_stream();
      test_backpressure();
      test_flush();
      test_reset_mid();
      test_wrap();
      test_stats();
      test_random();
      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule

// File: doc/pipe_stage_reg.md
# pipe_stage_reg

Parametrised elastic pipeline register. It replaces the fixed stall-only stage registers between the F/D/E/M/W stages. It carries instruction and PC through a valid/ready handshake with a 2-entry skid buffer, so a full-throughput stage's `in_ready` can be driven straight from a flop. It supports a flush that inserts a bubble, and an optional stall-cycle counter.

## Interface
- `INSTR_W`, 32, instruction field width.
- `PC_W`, 32, PC field width.
- `RESET_PC`, 32'h0000_3000, PC presented at `out_pc` after reset.
- `NOP_INSTR`, all-zero, instruction presented whenever the stage holds no valid beat.
- `clk`  in  1  clock; all state updates on rising edge.
- `reset`  in  1  synchronous, active-low reset (asserted when 0), sampled on rising edge of `clk`.
- `in_valid`  in  1  upstream beat present.
- `in_ready`  out  1  stage can accept a beat; driven directly from a flop.
- `in_instr`  in  INSTR_W  upstream instruction.
- `in_pc`  in  PC_W  upstream PC.
- `flush`  in  1  discard all held beats.
- `out_valid`  out  1  beat present at output.
- `out_ready`  in  1  downstream accepts; low = downstream stall.
- `out_instr`  out  INSTR_W  head instruction; NOP_INSTR when `out_valid`=0.
- `out_pc`  out  PC_W  head PC.
- `out_pc8`  out  PC_W  `out_pc` + 8, modulo 2^PC_W.
- `stall_cnt`  out  16  count of downstream-stall cycles (see Configuration).

## Operation
- Storage: main entry (drives outputs) and skid entry; each entry is {valid, instr, pc}.
- Input handshake: accept = `in_valid` & `in_ready`. Output handshake: take = `out_valid` & `out_ready`.
- State EMPTY (main invalid, skid invalid): on accept -> ONE, with the beat loaded into main.
- State ONE (main valid):
  - accept & take -> ONE, with main replaced by the input beat.
  - take only -> EMPTY.
  - accept only -> FULL, with the input beat loaded into skid.
  - neither -> hold.
- State FULL (both valid): `in_ready`=0. On take -> ONE, with skid moved into main and skid cleared.
- `out_valid` = main valid. `in_ready` = !skid valid.
- Beat order is preserved. No beat is duplicated or dropped, except by flush.
- Flush: next state EMPTY from any state. Both valid bits are cleared. A beat accepted in the flush cycle is dropped. The main pc register holds its value, so `out_pc` keeps the last PC.
- Flush and reset each take priority over all handshake activity in the same cycle. Reset takes priority over flush.
- `out_instr` is forced to NOP_INSTR whenever main is invalid. The stored instr bits are not exposed.
- `out_pc8` is combinational from the main pc register. It wraps at 2^PC_W, so with PC_W=32, 32'hFFFF_FFFC -> 32'h0000_0004.

## Timing
- Reset (`reset`=0 at an edge), with values from the next cycle:
  - `out_valid`=0, `in_ready`=1, `out_instr`=NOP_INSTR.
  - `out_pc`=RESET_PC (32'h3000), `out_pc8`=RESET_PC+8 (32'h3008), `stall_cnt`=0.
  - State is EMPTY.
- Reset asserted mid-stream discards both entries. No partially moved beat survives.
- Latency: a beat accepted at edge N appears on the outputs in the cycle after N.
- Throughput: with `out_ready` held 1, one beat per cycle and the stage never leaves ONE.
- Back-pressure: `in_ready` falls in the cycle after the skid fills, not in the cycle `out_ready` falls. The skid absorbs exactly that one beat.
- After one take in FULL, `in_ready` returns to 1 in the next cycle.
- Flush at edge N: `out_valid`=0 and `in_ready`=1 from the cycle after N.

## Configuration
- Macro `PIPE_STAGE_REG_STATS_EN`.
- Defined: `stall_cnt` increments on each cycle where `out_valid`=1 and `out_ready`=0.
  - It saturates at 16'hFFFF.
  - It clears only on reset; flush does not clear it.
- Undefined: there is no counter logic and `stall_cnt` is tied to 16'h0. The port list is identical in both builds.

## Test plan
- Reset then stream: release reset, send instr 0x1111/pc 0x3000, 0x2222/0x3004, 0x3333/0x3008 with `out_ready`=1. Required: the beats emerge on consecutive cycles, one cycle late, in order; `out_pc8` = 0x3008, 0x300C, 0x3010.
- Back-pressure: hold `out_ready`=0 while driving 3 beats. Required: 2 beats stored; `in_ready`=0 from the cycle after the second accept; the third beat is held upstream. Raise `out_ready`: all 3 beats appear in order, with no loss or duplicate.
- Flush in FULL: assert `flush` together with `in_valid`=1. Required: `out_valid`=0 and `out_instr`=0 next cycle; `in_ready`=1; the flush-cycle input beat is never output; `out_pc` holds its prior value.
- Reset mid-stream: in FULL, drive `reset`=0 for one edge. Required: `out_pc`=0x3000, `out_pc8`=0x3008, `out_valid`=0, `in_ready`=1.
- Wrap: PC 0xFFFF_FFFC. Required: `out_pc8`=0x0000_0004.
- Stats (macro defined): 5 stall cycles with `out_valid`=1. Required: `stall_cnt`=5. Macro undefined: `stall_cnt` stays 0.
